// File: rtl/lb_pkg.sv
// Shared types and defaults for the region load-balancing scheduler.
package lb_pkg;

    localparam int DEF_META_WIDTH     = 98;
    localparam int DEF_OID_WIDTH      = 16;
    localparam int DEF_N_REGIONS      = 4;
    localparam int DEF_LOAD_WIDTH     = 16;
    localparam int DEF_QDEPTH         = 16;
    localparam int DEF_LOAD_THRESHOLD = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_ISSUE,
        ST_PR_WAIT
    } lb_state_e;

    // Width of a region index; never narrower than one bit.
    function automatic int region_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lb_argmin.sv
// Masked minimum-load selector; equal loads resolve to the lowest index.
module lb_argmin #(
    parameter int N  = 4,
    parameter int LW = 16,
    parameter int IW = 2
) (
    input  logic [N-1:0]         mask_i,
    input  logic [N-1:0][LW-1:0] load_i,
    output logic                 valid_o,
    output logic [IW-1:0]        idx_o
);

    logic          found;
    logic [LW-1:0] best;

    always_comb begin
        found = 1'b0;
        best  = '0;
        idx_o = '0;
        // Strict less-than keeps the earliest index on ties.
        for (int i = 0; i < N; i++) begin
            if (mask_i[i] && (!found || load_i[i] < best)) begin
                found = 1'b1;
                best  = load_i[i];
                idx_o = IW'(i);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/lb_stream_queue.sv
// Synchronous stream FIFO; ready is held low through reset and while full.
module lb_stream_queue #(
    parameter int W     = 98,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         rdy_q;
    logic         full, empty, push, pop;

    assign empty       = (wr_q == rd_q);
    assign full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign in_ready_o  = rdy_q && !full;
    assign out_valid_o = !empty;
    assign out_data_o  = mem[rd_q[AW-1:0]];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_ready_i && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_q[AW-1:0]] <= in_data_i;
    end

endmodule

// File: rtl/lb_scheduler.sv
// Routes queued requests to the least-loaded region holding their operator,
// reconfiguring an idle region when no loaded region can take the request.
module lb_scheduler import lb_pkg::*; #(
    parameter int META_WIDTH        = DEF_META_WIDTH,
    parameter int OPERATOR_ID_WIDTH = DEF_OID_WIDTH,
    parameter int N_REGIONS         = DEF_N_REGIONS,
    parameter int LOAD_WIDTH        = DEF_LOAD_WIDTH,
    parameter int QDEPTH            = DEF_QDEPTH,
    parameter int LOAD_THRESHOLD    = DEF_LOAD_THRESHOLD
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic                                      meta_tvalid,
    output logic                                      meta_tready,
    input  logic [META_WIDTH-1:0]                     meta_tdata,
    input  logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0]    region_oid,
    input  logic [N_REGIONS*LOAD_WIDTH-1:0]           region_load,
    output logic                                      route_tvalid,
    input  logic                                      route_tready,
    output logic [META_WIDTH-1:0]                     route_tdata,
    output logic [region_idx_w(N_REGIONS)-1:0]        route_region,
    output logic                                      pr_req,
    output logic [region_idx_w(N_REGIONS)-1:0]        pr_region,
    output logic [OPERATOR_ID_WIDTH-1:0]              pr_oid,
    input  logic                                      pr_done,
    output logic [31:0]                               stat_dispatched,
    output logic [31:0]                               stat_reconfigs
);

    localparam int RW = region_idx_w(N_REGIONS);
    localparam int OW = OPERATOR_ID_WIDTH;
    localparam int LW = LOAD_WIDTH;

    lb_state_e               state_q, state_d;
    logic [META_WIDTH-1:0]   hold_q, hold_d;
    logic [RW-1:0]           route_region_q, route_region_d;
    logic                    pr_req_q, pr_req_d;
    logic [RW-1:0]           pr_region_q, pr_region_d;
    logic [OW-1:0]           pr_oid_q, pr_oid_d;
    logic [31:0]             disp_q, disp_d, reconf_q, reconf_d;

    logic                    fifo_valid;
    logic [META_WIDTH-1:0]   fifo_data;
    logic [OW-1:0]           req_oid;
    logic [N_REGIONS-1:0][OW-1:0] oid_a;
    logic [N_REGIONS-1:0][LW-1:0] load_a;
    logic [N_REGIONS-1:0]    match_mask, idle_mask;
    logic                    match_v, idle_v;
    logic [RW-1:0]           match_idx, idle_idx;

    lb_stream_queue #(.W(META_WIDTH), .DEPTH(QDEPTH)) u_queue (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .in_valid_i  (meta_tvalid),
        .in_ready_o  (meta_tready),
        .in_data_i   (meta_tdata),
        .out_valid_o (fifo_valid),
        .out_ready_i (state_q == ST_IDLE),
        .out_data_o  (fifo_data)
    );

    assign req_oid = hold_q[META_WIDTH-1 -: OW];

    always_comb begin
        for (int r = 0; r < N_REGIONS; r++) begin
            oid_a[r]      = region_oid[r*OW +: OW];
            load_a[r]     = region_load[r*LW +: LW];
            match_mask[r] = (oid_a[r] == req_oid) && (load_a[r] < LW'(LOAD_THRESHOLD));
            idle_mask[r]  = (load_a[r] == '0);
        end
    end

    lb_argmin #(.N(N_REGIONS), .LW(LW), .IW(RW)) u_match_sel (
        .mask_i  (match_mask),
        .load_i  (load_a),
        .valid_o (match_v),
        .idx_o   (match_idx)
    );

    // All idle candidates carry load 0, so this reduces to lowest-index pick.
    lb_argmin #(.N(N_REGIONS), .LW(LW), .IW(RW)) u_idle_sel (
        .mask_i  (idle_mask),
        .load_i  (load_a),
        .valid_o (idle_v),
        .idx_o   (idle_idx)
    );

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        route_region_d = route_region_q;
        pr_req_d       = 1'b0;
        pr_region_d    = pr_region_q;
        pr_oid_d       = pr_oid_q;
        disp_d         = disp_q;
        reconf_d       = reconf_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_valid) begin
                    hold_d  = fifo_data;
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (match_v) begin
                    route_region_d = match_idx;
                    state_d        = ST_ISSUE;
                end else if (idle_v) begin
                    pr_req_d    = 1'b1;
                    pr_region_d = idle_idx;
                    pr_oid_d    = req_oid;
                    state_d     = ST_PR_WAIT;
                end
            end
            ST_PR_WAIT: begin
                if (pr_done) begin
                    route_region_d = pr_region_q;
                    if (reconf_q != '1) reconf_d = reconf_q + 32'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (route_tready) begin
                    if (disp_q != '1) disp_d = disp_q + 32'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            hold_q         <= '0;
            route_region_q <= '0;
            pr_req_q       <= 1'b0;
            pr_region_q    <= '0;
            pr_oid_q       <= '0;
            disp_q         <= '0;
            reconf_q       <= '0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            route_region_q <= route_region_d;
            pr_req_q       <= pr_req_d;
            pr_region_q    <= pr_region_d;
            pr_oid_q       <= pr_oid_d;
            disp_q         <= disp_d;
            reconf_q       <= reconf_d;
        end
    end

    assign route_tvalid    = (state_q == ST_ISSUE);
    assign route_tdata     = hold_q;
    assign route_region    = route_region_q;
    assign pr_req          = pr_req_q;
    assign pr_region       = pr_region_q;
    assign pr_oid          = pr_oid_q;
    assign stat_dispatched = disp_q;
    assign stat_reconfigs  = reconf_q;

endmodule

// File: tb/tb_lb_scheduler.sv
// Directed scoreboard bench for lb_scheduler at default parameters.
module tb_lb_scheduler;

    logic         aclk, aresetn;
    logic         meta_tvalid, meta_tready;
    logic [97:0]  meta_tdata;
    logic [63:0]  region_oid, region_load;
    logic         route_tvalid, route_tready;
    logic [97:0]  route_tdata;
    logic [1:0]   route_region;
    logic         pr_req, pr_done;
    logic [1:0]   pr_region;
    logic [15:0]  pr_oid;
    logic [31:0]  stat_dispatched, stat_reconfigs;

    typedef struct packed {
        logic [97:0] data;
        logic [1:0]  region;
    } exp_t;

    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;
    int   pr_cnt = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;

    lb_scheduler dut (
        .aclk(aclk), .aresetn(aresetn),
        .meta_tvalid(meta_tvalid), .meta_tready(meta_tready), .meta_tdata(meta_tdata),
        .region_oid(region_oid), .region_load(region_load),
        .route_tvalid(route_tvalid), .route_tready(route_tready),
        .route_tdata(route_tdata), .route_region(route_region),
        .pr_req(pr_req), .pr_region(pr_region), .pr_oid(pr_oid), .pr_done(pr_done),
        .stat_dispatched(stat_dispatched), .stat_reconfigs(stat_reconfigs)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_asrt++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [97:0] mk(input logic [15:0] oid, input int tag);
        return {oid, 82'(tag)};
    endfunction

    task automatic set_regions(input logic [15:0] o0, o1, o2, o3,
                               input logic [15:0] l0, l1, l2, l3);
        region_oid  = {o3, o2, o1, o0};
        region_load = {l3, l2, l1, l0};
    endtask

    // Call at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic push(input logic [97:0] d, input logic [1:0] reg_exp, input bit expect_out);
        logic acc;
        int   n;
        exp_t e;
        e.data   = d;
        e.region = reg_exp;
        if (expect_out) sb.push_back(e);
        meta_tvalid = 1'b1;
        meta_tdata  = d;
        n = 0;
        do begin
            @(negedge aclk);
            acc = meta_tready;
            @(posedge aclk);
            n++;
        end while (!acc && n < 200);
        #1;
        meta_tvalid = 1'b0;
        if (!acc) chk("push_accept_timeout", {127'd0, acc}, 128'd1);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    task automatic wait_pr();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!pr_req && n < 50);
        chk("pr_req_seen", {127'd0, pr_req}, 128'd1);
    endtask

    // Scoreboard and protocol monitor
    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_v && !prev_r) chk("valid_held", {127'd0, route_tvalid}, 128'd1);
            if (route_tvalid && route_tready) begin
                chk("dispatch_expected", {127'd0, (sb.size() != 0)}, 128'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("route_tdata", 128'(route_tdata), 128'(e.data));
                    chk("route_region", 128'(route_region), 128'(e.region));
                end
            end
            if (pr_req) pr_cnt++;
        end
        prev_v = route_tvalid;
        prev_r = route_tready;
    end

    initial begin
        aresetn = 1'b0; meta_tvalid = 1'b0; meta_tdata = '0;
        route_tready = 1'b0; pr_done = 1'b0;
        set_regions(0, 0, 0, 0, 1, 1, 1, 1);

        // Reset state
        #22;
        chk("rst_meta_tready", 128'(meta_tready), 128'd0);
        chk("rst_route_tvalid", 128'(route_tvalid), 128'd0);
        chk("rst_route_tdata", 128'(route_tdata), 128'd0);
        chk("rst_pr_req", 128'(pr_req), 128'd0);
        chk("rst_stats", 128'({stat_dispatched, stat_reconfigs}), 128'd0);
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("ready_after_rst", 128'(meta_tready), 128'd1);

        // Match: oid 5 in regions 1 (load 4) and 3 (load 2)
        set_regions(16'h22, 16'h5, 16'h11, 16'h5, 1, 4, 1, 2);
        push(mk(16'h5, 1), 2'd3, 1'b1);
        @(negedge aclk); chk("lat_cycle0", 128'(route_tvalid), 128'd0);
        @(negedge aclk); chk("lat_cycle1", 128'(route_tvalid), 128'd0);
        @(negedge aclk); chk("lat_cycle2", 128'(route_tvalid), 128'd1);
        chk("match_region_early", 128'(route_region), 128'd3);
        @(posedge aclk); #1 route_tready = 1'b1;
        drain(10);
        chk("stat_disp_1", 128'(stat_dispatched), 128'd1);

        // Tie: regions 0 and 2 hold oid 7 at equal load
        set_regions(16'h7, 16'h8, 16'h7, 16'h8, 3, 5, 3, 5);
        push(mk(16'h7, 2), 2'd0, 1'b1);
        drain(10);
        chk("stat_disp_2", 128'(stat_dispatched), 128'd2);

        // Reconfigure: no region holds oid 9, region 2 idle
        set_regions(16'h1, 16'h2, 16'h3, 16'h4, 5, 5, 0, 6);
        push(mk(16'h9, 3), 2'd2, 1'b1);
        wait_pr();
        chk("pr_region", 128'(pr_region), 128'd2);
        chk("pr_oid", 128'(pr_oid), 128'h9);
        @(negedge aclk); chk("pr_req_one_cycle", 128'(pr_req), 128'd0);
        repeat (10) @(posedge aclk);
        #1 chk("no_route_in_pr_wait", 128'(route_tvalid), 128'd0);
        pr_done = 1'b1;
        @(posedge aclk); #1 pr_done = 1'b0;
        drain(10);
        chk("stat_reconf_1", 128'(stat_reconfigs), 128'd1);
        chk("pr_cnt_1", 128'(pr_cnt), 128'd1);

        // Stall: every region saturated, none idle
        set_regions(16'h3, 16'hA, 16'h3, 16'h3, 8, 8, 8, 8);
        push(mk(16'hA, 4), 2'd1, 1'b1);
        repeat (8) @(posedge aclk);
        #1;
        chk("stall_no_route", 128'(route_tvalid), 128'd0);
        chk("stall_no_pr", 128'(pr_cnt), 128'd1);
        set_regions(16'h3, 16'hA, 16'h3, 16'h3, 8, 3, 8, 8);
        drain(10);
        chk("stat_disp_4", 128'(stat_dispatched), 128'd4);

        // Backpressure: 17 words with the output blocked
        route_tready = 1'b0;
        set_regions(16'hB, 16'hB, 16'hB, 16'hB, 2, 1, 3, 4);
        for (int i = 0; i < 17; i++) push(mk(16'hB, 100 + i), 2'd1, 1'b1);
        @(negedge aclk); chk("full_ready_low", 128'(meta_tready), 128'd0);
        repeat (3) @(negedge aclk);
        chk("full_ready_still_low", 128'(meta_tready), 128'd0);
        chk("full_valid_held", 128'(route_tvalid), 128'd1);
        @(posedge aclk); #1 route_tready = 1'b1;
        drain(200);
        chk("stat_disp_21", 128'(stat_dispatched), 128'd21);
        chk("ready_after_drain", 128'(meta_tready), 128'd1);

        // Reset in the middle of PR_WAIT
        set_regions(16'h1, 16'h2, 16'h3, 16'h4, 5, 5, 5, 0);
        push(mk(16'hC, 5), 2'd3, 1'b0);
        wait_pr();
        chk("pr_region_3", 128'(pr_region), 128'd3);
        @(posedge aclk); #1 aresetn = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_route", 128'({route_tvalid, route_region}), 128'd0);
        chk("mid_rst_tdata", 128'(route_tdata), 128'd0);
        chk("mid_rst_pr", 128'({pr_req, pr_region, pr_oid}), 128'd0);
        chk("mid_rst_stats", 128'({stat_dispatched, stat_reconfigs}), 128'd0);
        chk("mid_rst_ready", 128'(meta_tready), 128'd0);
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("ready_after_rst2", 128'(meta_tready), 128'd1);
        pr_done = 1'b1;
        @(posedge aclk); #1 pr_done = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        chk("post_rst_no_route", 128'(route_tvalid), 128'd0);
        chk("post_rst_reconf", 128'(stat_reconfigs), 128'd0);
        chk("post_rst_disp", 128'(stat_dispatched), 128'd0);
        chk("pr_cnt_2", 128'(pr_cnt), 128'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
